// File: rtl/pong_pkg.sv
// pong_pkg: shared types for the ball direction/rally controller.
//   state_e  - rally FSM states
//   DIR_*    - direction codes understood by the ball position block
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_SCORED,
    ST_GAME_OVER
  } state_e;

  localparam logic [1:0] DIR_POS  = 2'b10;
  localparam logic [1:0] DIR_NEG  = 2'b01;
  localparam logic [1:0] DIR_NONE = 2'b00;

endpackage

// File: rtl/ball_hit_detect.sv
// ball_hit_detect: combinational collision/miss detection for one game step.
// Ports:
//   x_pos, y_pos                   in  ball top-left corner
//   left_paddle_y, right_paddle_y  in  paddle top edges
//   x_dir, y_dir                   in  current direction codes
//   hit_top, hit_bot               out wall reversal needed
//   hit_lpad, hit_rpad             out paddle face reversal needed
//   miss_l, miss_r                 out ball left the field on that side
module ball_hit_detect
  import pong_pkg::*;
#(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616
) (
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [9:0] left_paddle_y,
  input  logic [9:0] right_paddle_y,
  input  logic [1:0] x_dir,
  input  logic [1:0] y_dir,
  output logic       hit_top,
  output logic       hit_bot,
  output logic       hit_lpad,
  output logic       hit_rpad,
  output logic       miss_l,
  output logic       miss_r
);

  // All arithmetic is carried in 11 bits so pos+size never wraps.
  localparam logic [10:0] BS       = 11'(BALL_SIZE);
  localparam logic [10:0] PH       = 11'(PADDLE_H);
  localparam logic [10:0] TOP_LIM  = 11'(SCREEN_H - BALL_SIZE - 1);
  localparam logic [10:0] LPAD_FACE = 11'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [10:0] RPAD_FACE = 11'(RIGHT_PADDLE_X);
  localparam logic [10:0] SW       = 11'(SCREEN_W);

  logic [10:0] x_ext, y_ext, lp_ext, rp_ext;
  logic        ovl_l, ovl_r;

  assign x_ext  = {1'b0, x_pos};
  assign y_ext  = {1'b0, y_pos};
  assign lp_ext = {1'b0, left_paddle_y};
  assign rp_ext = {1'b0, right_paddle_y};

  assign ovl_l = (y_ext + BS > lp_ext) && (y_ext < lp_ext + PH);
  assign ovl_r = (y_ext + BS > rp_ext) && (y_ext < rp_ext + PH);

  assign hit_top  = (y_dir == DIR_POS) && (y_ext >= TOP_LIM);
  assign hit_bot  = (y_dir == DIR_NEG) && (y_pos == 10'd0);
  assign hit_lpad = (x_dir == DIR_NEG) && (x_ext == LPAD_FACE) && ovl_l;
  assign hit_rpad = (x_dir == DIR_POS) && (x_ext + BS == RPAD_FACE) && ovl_r;
  assign miss_l   = (x_dir == DIR_NEG) && (x_pos == 10'd0);
  assign miss_r   = (x_dir == DIR_POS) && (x_ext + BS >= SW);

endmodule

// File: rtl/ball_dir_ctrl.sv
// ball_dir_ctrl: rally sequencer driving the ball position block
// (ball pause = ~move, ball reset = ball_rst at the top level).
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | waiting for start, ball held
// SERVE     | ball reloaded, counting SERVE_TICKS ticks
// PLAY      | each tick: bounce/miss evaluation, move strobe
// SCORED    | one cycle to decide next serve or game over
// GAME_OVER | scores frozen until start
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   tick, start                  game-step strobe, start level
//   x_pos, y_pos                 ball position
//   left_paddle_y/right_paddle_y paddle top edges
//   x_dir, y_dir, move, ball_rst ball block controls (registered)
//   score_l, score_r, game_over  score/status (registered)
module ball_dir_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int SERVE_TICKS    = 60,
  parameter int WIN_SCORE      = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [9:0] left_paddle_y,
  input  logic [9:0] right_paddle_y,
  output logic [1:0] x_dir,
  output logic [1:0] y_dir,
  output logic       move,
  output logic       ball_rst,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over
);

  localparam int          CNT_W    = $clog2(SERVE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_TICKS - 1);
  localparam logic [3:0]  WIN      = 4'(WIN_SCORE);

  state_e             state_q, state_d;
  logic [1:0]         x_dir_q, x_dir_d, y_dir_q, y_dir_d, serve_x_q, serve_x_d;
  logic               move_q, move_d, ball_rst_q, ball_rst_d, game_over_q, game_over_d;
  logic [3:0]         score_l_q, score_l_d, score_r_q, score_r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hit_top, hit_bot, hit_lpad, hit_rpad, miss_l, miss_r;

  ball_hit_detect #(
    .SCREEN_W      (SCREEN_W),
    .SCREEN_H      (SCREEN_H),
    .BALL_SIZE     (BALL_SIZE),
    .PADDLE_W      (PADDLE_W),
    .PADDLE_H      (PADDLE_H),
    .LEFT_PADDLE_X (LEFT_PADDLE_X),
    .RIGHT_PADDLE_X(RIGHT_PADDLE_X)
  ) u_hit (
    .x_pos         (x_pos),
    .y_pos         (y_pos),
    .left_paddle_y (left_paddle_y),
    .right_paddle_y(right_paddle_y),
    .x_dir         (x_dir_q),
    .y_dir         (y_dir_q),
    .hit_top       (hit_top),
    .hit_bot       (hit_bot),
    .hit_lpad      (hit_lpad),
    .hit_rpad      (hit_rpad),
    .miss_l        (miss_l),
    .miss_r        (miss_r)
  );

  always_comb begin
    state_d    = state_q;
    x_dir_d    = x_dir_q;
    y_dir_d    = y_dir_q;
    serve_x_d  = serve_x_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    cnt_d      = cnt_q;
    move_d     = 1'b0;
    ball_rst_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        x_dir_d = DIR_NONE;
        y_dir_d = DIR_NONE;
        if (start) begin
          state_d    = ST_SERVE;
          ball_rst_d = 1'b1;
          cnt_d      = '0;
        end
      end
      ST_SERVE: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            x_dir_d = serve_x_q;
            y_dir_d = DIR_POS;
            cnt_d   = '0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (tick) begin
          // A miss ends the rally outright; no wall bounce and no step.
          if (miss_l) begin
            if (score_r_q < WIN) score_r_d = score_r_q + 4'd1;
            serve_x_d = DIR_NEG;
            x_dir_d   = DIR_NONE;
            y_dir_d   = DIR_NONE;
            state_d   = ST_SCORED;
          end else if (miss_r) begin
            if (score_l_q < WIN) score_l_d = score_l_q + 4'd1;
            serve_x_d = DIR_POS;
            x_dir_d   = DIR_NONE;
            y_dir_d   = DIR_NONE;
            state_d   = ST_SCORED;
          end else begin
            move_d = 1'b1;
            if (hit_lpad) x_dir_d = DIR_POS;
            if (hit_rpad) x_dir_d = DIR_NEG;
            if (hit_top)  y_dir_d = DIR_NEG;
            if (hit_bot)  y_dir_d = DIR_POS;
          end
        end
      end
      ST_SCORED: begin
        if (score_l_q == WIN || score_r_q == WIN) begin
          state_d = ST_GAME_OVER;
        end else begin
          state_d    = ST_SERVE;
          ball_rst_d = 1'b1;
          cnt_d      = '0;
        end
      end
      ST_GAME_OVER: begin
        x_dir_d = DIR_NONE;
        y_dir_d = DIR_NONE;
        if (start) begin
          score_l_d  = '0;
          score_r_d  = '0;
          serve_x_d  = DIR_POS;
          cnt_d      = '0;
          ball_rst_d = 1'b1;
          state_d    = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    game_over_d = (state_d == ST_GAME_OVER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      x_dir_q     <= DIR_NONE;
      y_dir_q     <= DIR_NONE;
      serve_x_q   <= DIR_POS;
      score_l_q   <= '0;
      score_r_q   <= '0;
      cnt_q       <= '0;
      move_q      <= 1'b0;
      ball_rst_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_dir_q     <= x_dir_d;
      y_dir_q     <= y_dir_d;
      serve_x_q   <= serve_x_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      cnt_q       <= cnt_d;
      move_q      <= move_d;
      ball_rst_q  <= ball_rst_d;
      game_over_q <= game_over_d;
    end
  end

  assign x_dir     = x_dir_q;
  assign y_dir     = y_dir_q;
  assign move      = move_q;
  assign ball_rst  = ball_rst_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_ball_dir_ctrl.sv
// tb_ball_dir_ctrl: scenario tests for ball_dir_ctrl. Expected output words
// are queued when stimulus is driven and popped/compared once the DUT has
// registered the step.
module tb_ball_dir_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, tick, start;
  logic [9:0] x_pos, y_pos, left_paddle_y, right_paddle_y;
  logic [1:0] x_dir, y_dir;
  logic       move, ball_rst, game_over;
  logic [3:0] score_l, score_r;

  ball_dir_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tick          (tick),
    .start         (start),
    .x_pos         (x_pos),
    .y_pos         (y_pos),
    .left_paddle_y (left_paddle_y),
    .right_paddle_y(right_paddle_y),
    .x_dir         (x_dir),
    .y_dir         (y_dir),
    .move          (move),
    .ball_rst      (ball_rst),
    .score_l       (score_l),
    .score_r       (score_r),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] v;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  logic [14:0] obs;

  assign obs = {x_dir, y_dir, move, ball_rst, score_l, score_r, game_over};

  function automatic logic [14:0] pk(logic [1:0] xd, logic [1:0] yd, logic mv,
                                     logic br, logic [3:0] sl, logic [3:0] sr,
                                     logic go);
    return {xd, yd, mv, br, sl, sr, go};
  endfunction

  // One-cycle stimulus: inputs applied at negedge, returns 1 time unit after
  // the following posedge with tick/start already released.
  task automatic clk_in(input logic t, input logic s);
    @(negedge clk);
    tick  = t;
    start = s;
    @(posedge clk);
    #1;
    tick  = 1'b0;
    start = 1'b0;
  endtask

  task automatic serve_ticks(input int n);
    repeat (n) clk_in(1'b1, 1'b0);
  endtask

  task automatic set_pos(input int x, input int y);
    x_pos = 10'(x);
    y_pos = 10'(y);
  endtask

  task automatic test_reset;
    sb.push_back('{pk(2'b00, 2'b00, 0, 0, 4'd0, 4'd0, 0), "reset_state"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    @(negedge clk);
    reset_n = 1'b1;
    clk_in(1'b1, 1'b0);
    sb.push_back('{pk(2'b00, 2'b00, 0, 0, 4'd0, 4'd0, 0), "idle_tick_ignored"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
  endtask

  task automatic test_serve;
    int br_cnt, mv_cnt;
    set_pos(300, 200);
    clk_in(1'b0, 1'b1);
    sb.push_back('{pk(2'b00, 2'b00, 0, 1, 4'd0, 4'd0, 0), "serve_ball_rst"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    br_cnt = int'(ball_rst);
    mv_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      clk_in(1'b1, 1'b0);
      br_cnt += int'(ball_rst);
      mv_cnt += int'(move);
    end
    sb.push_back('{pk(2'b10, 2'b10, 0, 0, 4'd0, 4'd0, 0), "serve_dirs"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    total++;
    if (br_cnt !== 1) begin bad++; $display("FAIL serve_rst_pulses got=%0d want=1", br_cnt); end
    total++;
    if (mv_cnt !== 0) begin bad++; $display("FAIL serve_no_move got=%0d want=0", mv_cnt); end
    clk_in(1'b1, 1'b0);
    sb.push_back('{pk(2'b10, 2'b10, 1, 0, 4'd0, 4'd0, 0), "play_move"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    clk_in(1'b0, 1'b0);
    sb.push_back('{pk(2'b10, 2'b10, 0, 0, 4'd0, 4'd0, 0), "move_one_cycle"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
  endtask

  task automatic test_walls;
    int ys[4]           = '{470, 471, 1, 0};
    logic [1:0] yexp[4] = '{2'b10, 2'b01, 2'b01, 2'b10};
    string nm[4]        = '{"top_minus1", "top_bounce", "bot_plus1", "bot_bounce"};
    for (int i = 0; i < 4; i++) begin
      set_pos(300, ys[i]);
      clk_in(1'b1, 1'b0);
      sb.push_back('{pk(2'b10, yexp[i], 1, 0, 4'd0, 4'd0, 0), nm[i]});
      e = sb.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    end
  endtask

  task automatic test_right_paddle;
    set_pos(608, 100);
    right_paddle_y = 10'd108;
    clk_in(1'b1, 1'b0);
    sb.push_back('{pk(2'b10, 2'b10, 1, 0, 4'd0, 4'd0, 0), "rpad_edge_no_hit"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    right_paddle_y = 10'd80;
    clk_in(1'b1, 1'b0);
    sb.push_back('{pk(2'b01, 2'b10, 1, 0, 4'd0, 4'd0, 0), "rpad_hit"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
  endtask

  task automatic test_corner;
    set_pos(300, 471);
    clk_in(1'b1, 1'b0);
    sb.push_back('{pk(2'b01, 2'b01, 1, 0, 4'd0, 4'd0, 0), "pre_corner_dirs"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    set_pos(24, 0);
    left_paddle_y = 10'd0;
    clk_in(1'b1, 1'b0);
    sb.push_back('{pk(2'b10, 2'b10, 1, 0, 4'd0, 4'd0, 0), "corner"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
  endtask

  task automatic test_right_miss;
    set_pos(632, 100);
    right_paddle_y = 10'd300;
    clk_in(1'b1, 1'b0);
    sb.push_back('{pk(2'b00, 2'b00, 0, 0, 4'd1, 4'd0, 0), "rmiss"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    clk_in(1'b0, 1'b0);
    sb.push_back('{pk(2'b00, 2'b00, 0, 1, 4'd1, 4'd0, 0), "rmiss_serve"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    set_pos(300, 200);
    serve_ticks(60);
    sb.push_back('{pk(2'b10, 2'b10, 0, 0, 4'd1, 4'd0, 0), "rmiss_reserve"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
  endtask

  task automatic test_game_over;
    set_pos(608, 100);
    right_paddle_y = 10'd80;
    clk_in(1'b1, 1'b0);
    sb.push_back('{pk(2'b01, 2'b10, 1, 0, 4'd1, 4'd0, 0), "go_pad_bounce"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    for (int k = 1; k <= 7; k++) begin
      set_pos(0, 200);
      clk_in(1'b1, 1'b0);
      sb.push_back('{pk(2'b00, 2'b00, 0, 0, 4'd1, 4'(k), 0), $sformatf("lmiss_%0d", k)});
      e = sb.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
      clk_in(1'b0, 1'b0);
      if (k < 7) begin
        sb.push_back('{pk(2'b00, 2'b00, 0, 1, 4'd1, 4'(k), 0), $sformatf("lmiss_serve_%0d", k)});
        e = sb.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
        serve_ticks(60);
        sb.push_back('{pk(2'b01, 2'b10, 0, 0, 4'd1, 4'(k), 0), $sformatf("lmiss_reserve_%0d", k)});
        e = sb.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
      end else begin
        sb.push_back('{pk(2'b00, 2'b00, 0, 0, 4'd1, 4'd7, 1), "game_over"});
        e = sb.pop_front(); total++;
        if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
      end
    end
    clk_in(1'b1, 1'b0);
    sb.push_back('{pk(2'b00, 2'b00, 0, 0, 4'd1, 4'd7, 1), "go_tick_ignored"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    clk_in(1'b0, 1'b1);
    sb.push_back('{pk(2'b00, 2'b00, 0, 1, 4'd0, 4'd0, 0), "go_restart"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    set_pos(300, 200);
    serve_ticks(60);
    sb.push_back('{pk(2'b10, 2'b10, 0, 0, 4'd0, 4'd0, 0), "restart_serve_x"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
  endtask

  task automatic test_reset_mid_play;
    set_pos(300, 200);
    clk_in(1'b1, 1'b0);
    sb.push_back('{pk(2'b10, 2'b10, 1, 0, 4'd0, 4'd0, 0), "pre_reset_move"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    reset_n = 1'b0;
    #1;
    sb.push_back('{pk(2'b00, 2'b00, 0, 0, 4'd0, 4'd0, 0), "async_reset"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
    @(negedge clk);
    reset_n = 1'b1;
    clk_in(1'b1, 1'b0);
    sb.push_back('{pk(2'b00, 2'b00, 0, 0, 4'd0, 4'd0, 0), "post_reset_idle"});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs, e.v); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    tick           = 1'b0;
    start          = 1'b0;
    x_pos          = 10'd300;
    y_pos          = 10'd200;
    left_paddle_y  = 10'd200;
    right_paddle_y = 10'd200;
    #12;
    test_reset;
    test_serve;
    test_walls;
    test_right_paddle;
    test_corner;
    test_right_miss;
    test_game_over;
    test_reset_mid_play;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ball_dir_ctrl.md
# ball_dir_ctrl

Direction and rally controller driving the ball position block. It watches the ball position and both paddle positions, then issues registered `x_dir`/`y_dir` codes, a one-cycle `move` strobe and a `ball_rst` pulse. It bounces the ball off walls and paddles, detects misses, keeps score and sequences serve, play and game-over. It sits between the paddle inputs and the ball block. Top level ties ball `pause = ~move` and ball `reset = ball_rst`.

## Interface

Parameters:
- `SCREEN_W`, 640, playfield width in pixels
- `SCREEN_H`, 480, playfield height in pixels
- `BALL_SIZE`, 8, ball edge length
- `PADDLE_W`, 8, paddle width
- `PADDLE_H`, 64, paddle height
- `LEFT_PADDLE_X`, 16, left paddle left edge
- `RIGHT_PADDLE_X`, 616, right paddle left edge
- `SERVE_TICKS`, 60, ticks held in SERVE
- `WIN_SCORE`, 7, points that end the game

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `tick`  in  1  one-cycle game-step strobe
- `start`  in  1  level; leaves IDLE / GAME_OVER
- `x_pos`, `y_pos`  in  10  ball top-left corner
- `left_paddle_y`, `right_paddle_y`  in  10  paddle top edges
- `x_dir`, `y_dir`  out  2  direction code: 2'b10 increment, 2'b01 decrement, 2'b00 hold
- `move`  out  1  one-cycle ball step enable
- `ball_rst`  out  1  one-cycle ball reload pulse, active-high
- `score_l`, `score_r`  out  4  scores
- `game_over`  out  1  high in GAME_OVER

## Operation

- **States:** IDLE, SERVE, PLAY, SCORED, GAME_OVER.
- **IDLE:**
  - Dirs are 00 and `move` is 0.
  - `start` -> SERVE.
- **SERVE:**
  - `ball_rst` is high on the first SERVE cycle only.
  - Tick counter counts from 0.
  - After `SERVE_TICKS` ticks: `x_dir` <= `serve_x`, `y_dir` <= 10, go to PLAY.
  - `serve_x` resets to 10.
- **PLAY**, evaluated only on a `tick` cycle, using the current positions. All sums are 11-bit; no wrap is permitted.
  - Top wall: `y_dir`==10 and `y_pos` >= `SCREEN_H-BALL_SIZE-1` -> `y_dir` <= 01.
  - Bottom wall: `y_dir`==01 and `y_pos`==0 -> `y_dir` <= 10.
  - Overlap with paddle at `p`: `y_pos+BALL_SIZE > p` and `y_pos < p+PADDLE_H`.
  - Left paddle: `x_dir`==01, `x_pos`==`LEFT_PADDLE_X+PADDLE_W`, overlap with `left_paddle_y` -> `x_dir` <= 10.
  - Right paddle: `x_dir`==10, `x_pos+BALL_SIZE`==`RIGHT_PADDLE_X`, overlap with `right_paddle_y` -> `x_dir` <= 01.
  - Left miss: `x_dir`==01, `x_pos`==0 -> `score_r`++, `serve_x` <= 01, go to SCORED.
  - Right miss: `x_dir`==10, `x_pos+BALL_SIZE` >= `SCREEN_W` -> `score_l`++, `serve_x` <= 10, go to SCORED.
  - Corners: an x and a y reversal on the same tick both apply.
  - A miss outranks any wall bounce; on a miss, dirs <= 00.
- **SCORED:** lasts one cycle. If either score equals `WIN_SCORE` -> GAME_OVER, else -> SERVE.
- **GAME_OVER:**
  - Dirs are 00 and scores are frozen.
  - `start` -> clear scores, `serve_x` <= 10, go to SERVE.
- Scores never exceed `WIN_SCORE`.

## Timing

- **Reset:** asynchronous assertion forces, at any point including mid-rally:
  - state IDLE
  - `x_dir`, `y_dir` = 00
  - `move`, `ball_rst`, `game_over` = 0
  - scores = 0, `serve_x` = 10, counter = 0
- **Move latency:**
  - A PLAY tick at cycle t registers the new dirs, visible at t+1.
  - `move` is high exactly at t+1, so the ball steps with the updated direction.
  - `move` is never high outside PLAY, and never high on the tick that triggers a miss.
- **`ball_rst`:** registered; high on the cycle after the transition into SERVE.
- **Idle input:** `tick` is ignored in IDLE, SCORED and GAME_OVER. `start` is ignored in SERVE and PLAY.
- **All outputs** are registered.

## Structure

- Package `pong_pkg`:
  - state enum
  - `DIR_POS`=2'b10, `DIR_NEG`=2'b01, `DIR_NONE`=2'b00
- Sub-module `ball_hit_detect`:
  - purely combinational
  - takes positions and parameters
  - returns `hit_top`, `hit_bot`, `hit_lpad`, `hit_rpad`, `miss_l`, `miss_r`
- FSM, counters and scores live in `ball_dir_ctrl`.

## Test plan

- **Serve:** reset, `start`, 60 ticks -> `ball_rst` pulses once, then `x_dir`=10, `y_dir`=10, `move` follows each tick by one cycle.
- **Top bounce:** PLAY, `y_dir`=10, `y_pos`=471, tick -> `y_dir`=01 next cycle, `move`=1 same cycle.
- **Right paddle hit:** `x_dir`=10, `x_pos`=608, `y_pos`=100, `right_paddle_y`=80, tick -> `x_dir`=01.
- **Right miss:** `x_dir`=10, `x_pos`=632, `right_paddle_y`=300, `y_pos`=100 -> `score_l`=1, no `move`, SERVE, later `x_dir`=10.
- **Corner:** left paddle face and bottom wall together (`x_pos`=24, `y_pos`=0, `left_paddle_y`=0, dirs 01/01) -> both dirs become 10.
- **Game over and reset:**
  - `score_r` reaches 7 -> `game_over`=1, dirs 00; `start` -> scores 0.
  - `reset_n` low mid-PLAY -> all outputs 0 immediately.
